chess_move_controller: RTL and testbench

Move-sequencing and chess-clock controller for the board layout matrix. It takes the cursor square index and Select/Cancel keys, reads the addressed square, and validates source and destination ownership. It commits each move as two write cycles into the layout matrix, alternates turns and counts down each player's remaining time. It sits between the key/cursor logic and the layout matrix write port, and it is the only writer of piece nibbles.

---
 rtl/chess_move_controller.sv | 199 +++++++++++++++++++
 tb/tb_chess_move_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_move_controller.sv
// chess_move_controller: two-key move sequencer and chess clock in front of the
// board layout matrix. Reads the square under the cursor, checks source and
// destination ownership, commits a move as a destination write followed by a
// source clear, alternates turns and counts down each side's remaining seconds.
module chess_move_controller #(
    parameter int TICK_CYCLES  = 50_000_000,
    parameter int TURN_SECONDS = 600,
    parameter int SQUARE_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    resetApp,
    input  logic                    KeySelect,
    input  logic                    KeyCancel,
    input  logic [5:0]              CursorIdx,
    output logic [5:0]              RdIdx,
    input  logic [SQUARE_WIDTH-1:0] RdData,
    output logic                    WrEn,
    output logic [5:0]              WrIdx,
    output logic [SQUARE_WIDTH-1:0] WrData,
    output logic                    Turn,
    output logic                    SrcValid,
    output logic [5:0]              SrcIdx,
    output logic [9:0]              WhiteTime,
    output logic [9:0]              BlackTime,
    output logic                    GameOver,
    output logic                    Winner
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [3:0] S_WAIT_SRC  = 4'd0;
    localparam logic [3:0] S_READ_SRC  = 4'd1;
    localparam logic [3:0] S_CHECK_SRC = 4'd2;
    localparam logic [3:0] S_WAIT_DST  = 4'd3;
    localparam logic [3:0] S_READ_DST  = 4'd4;
    localparam logic [3:0] S_CHECK_DST = 4'd5;
    localparam logic [3:0] S_WRITE_DST = 4'd6;
    localparam logic [3:0] S_WRITE_SRC = 4'd7;
    localparam logic [3:0] S_OVER      = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [2:0]       sel_q, can_q;
    logic [5:0]       rd_q, rd_d, src_q, src_d, dst_q, dst_d;
    logic [3:0]       piece_q, piece_d;
    logic             srcv_q, srcv_d, king_q, king_d, turn_q, turn_d;
    logic             over_q, over_d, win_q, win_d;
    logic [9:0]       white_q, white_d, black_q, black_d;
    logic [CNT_W-1:0] tick_q;

    // Overlay nibble of the read square is display-only; ownership uses the piece nibble.
    logic       rd_overlay_unused;
    assign rd_overlay_unused = ^RdData[SQUARE_WIDTH-1:4];

    logic [3:0] rd_piece;
    logic       own, can_p, sel_p, tick_wrap, timeout, mover_zero_next;
    assign rd_piece  = RdData[3:0];
    assign own       = (rd_piece != 4'h0) && (rd_piece[3] == turn_q);
    assign can_p     = can_q[2] & ~can_q[1];
    assign sel_p     = sel_q[2] & ~sel_q[1] & ~can_p;
    assign tick_wrap = (tick_q == CNT_W'(TICK_CYCLES - 1));
    assign timeout   = ((turn_q ? black_q : white_q) == 10'd0);
    assign mover_zero_next = ((turn_q ? black_d : white_d) == 10'd0);

    // Second timer and key synchronizers; the tick counter never restarts on a turn change.
    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            tick_q  <= '0;
            sel_q   <= 3'b111;
            can_q   <= 3'b111;
            white_q <= 10'(TURN_SECONDS);
            black_q <= 10'(TURN_SECONDS);
        end else begin
            tick_q  <= tick_wrap ? '0 : tick_q + CNT_W'(1);
            sel_q   <= {sel_q[1:0], KeySelect};
            can_q   <= {can_q[1:0], KeyCancel};
            white_q <= white_d;
            black_q <= black_d;
        end
    end

    // Side to move loses one second per wrap, saturating, frozen once the game ends.
    always_comb begin
        white_d = white_q;
        black_d = black_q;
        if (tick_wrap && state_q != S_OVER) begin
            if (turn_q) black_d = (black_q == 10'd0) ? 10'd0 : black_q - 10'd1;
            else        white_d = (white_q == 10'd0) ? 10'd0 : white_q - 10'd1;
        end
    end

    // Move sequencer; a flag fall outside the write pair ends the game at once.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        src_d   = src_q;
        dst_d   = dst_q;
        piece_d = piece_q;
        srcv_d  = srcv_q;
        king_d  = king_q;
        turn_d  = turn_q;
        over_d  = over_q;
        win_d   = win_q;
        if (timeout && state_q != S_WRITE_DST && state_q != S_WRITE_SRC && state_q != S_OVER) begin
            state_d = S_OVER;
            over_d  = 1'b1;
            win_d   = ~turn_q;
            srcv_d  = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_SRC: if (sel_p) begin
                    rd_d    = CursorIdx;
                    state_d = S_READ_SRC;
                end
                S_READ_SRC:  state_d = S_CHECK_SRC;
                S_CHECK_SRC: if (own) begin
                    src_d   = rd_q;
                    piece_d = rd_piece;
                    srcv_d  = 1'b1;
                    state_d = S_WAIT_DST;
                end else begin
                    state_d = S_WAIT_SRC;
                end
                S_WAIT_DST: if (can_p || (sel_p && CursorIdx == src_q)) begin
                    srcv_d  = 1'b0;
                    state_d = S_WAIT_SRC;
                end else if (sel_p) begin
                    rd_d    = CursorIdx;
                    dst_d   = CursorIdx;
                    state_d = S_READ_DST;
                end
                S_READ_DST:  state_d = S_CHECK_DST;
                S_CHECK_DST: if (own) begin
                    state_d = S_WAIT_DST;
                end else begin
                    king_d  = (rd_piece[2:0] == 3'd6);
                    state_d = S_WRITE_DST;
                end
                S_WRITE_DST: state_d = S_WRITE_SRC;
                S_WRITE_SRC: begin
                    srcv_d = 1'b0;
                    if (king_q) begin
                        state_d = S_OVER;
                        over_d  = 1'b1;
                        win_d   = turn_q;
                    end else if (mover_zero_next) begin
                        state_d = S_OVER;
                        over_d  = 1'b1;
                        win_d   = ~turn_q;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_WAIT_SRC;
                    end
                end
                default: state_d = S_OVER;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            state_q <= S_WAIT_SRC;
            rd_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            piece_q <= '0;
            srcv_q  <= 1'b0;
            king_q  <= 1'b0;
            turn_q  <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            piece_q <= piece_d;
            srcv_q  <= srcv_d;
            king_q  <= king_d;
            turn_q  <= turn_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    // Write port decoded from state so reset drops WrEn without a clock.
    assign WrEn      = (state_q == S_WRITE_DST) || (state_q == S_WRITE_SRC);
    assign WrIdx     = (state_q == S_WRITE_DST) ? dst_q : (state_q == S_WRITE_SRC) ? src_q : 6'd0;
    assign WrData    = (state_q == S_WRITE_DST) ? SQUARE_WIDTH'(piece_q) : '0;
    assign RdIdx     = rd_q;
    assign Turn      = turn_q;
    assign SrcValid  = srcv_q;
    assign SrcIdx    = src_q;
    assign WhiteTime = white_q;
    assign BlackTime = black_q;
    assign GameOver  = over_q;
    assign Winner    = win_q;

endmodule

// File: tb/tb_chess_move_controller.sv
// Bench for chess_move_controller: a board memory with registered read, an
// action-level game model (board, turn, held source) and directed scenarios.
module tb_chess_move_controller;

    localparam int TK  = 16;
    localparam int TS  = 600;
    localparam int TK2 = 4;
    localparam int TS2 = 3;

    logic       clock = 1'b0, resetApp = 1'b0, KeySelect = 1'b1, KeyCancel = 1'b1;
    logic [5:0] CursorIdx = 6'd0;
    logic [5:0] RdIdx, WrIdx, SrcIdx;
    logic [7:0] RdData = 8'h00, WrData;
    logic       WrEn, Turn, SrcValid, GameOver, Winner;
    logic [9:0] WhiteTime, BlackTime;

    logic [5:0] RdIdx2, WrIdx2, SrcIdx2;
    logic [7:0] RdData2 = 8'h00, WrData2;
    logic       WrEn2, Turn2, SrcValid2, GameOver2, Winner2;
    logic [9:0] WhiteTime2, BlackTime2;
    logic       KeyIdle = 1'b1;

    int checks = 0, failures = 0;
    int cyc;
    logic [7:0] mem [64];
    logic [7:0] init_mem [64];
    logic       load = 1'b0;
    int         wq_idx [$];
    int         wq_cyc [$];
    logic [7:0] wq_dat [$];

    // model state
    logic [7:0] mb [64];
    bit m_turn, m_sv, m_over, m_win;
    int m_src;

    chess_move_controller #(.TICK_CYCLES(TK), .TURN_SECONDS(TS), .SQUARE_WIDTH(8)) dut (
        .clock(clock), .resetApp(resetApp), .KeySelect(KeySelect), .KeyCancel(KeyCancel),
        .CursorIdx(CursorIdx), .RdIdx(RdIdx), .RdData(RdData), .WrEn(WrEn), .WrIdx(WrIdx),
        .WrData(WrData), .Turn(Turn), .SrcValid(SrcValid), .SrcIdx(SrcIdx),
        .WhiteTime(WhiteTime), .BlackTime(BlackTime), .GameOver(GameOver), .Winner(Winner));

    chess_move_controller #(.TICK_CYCLES(TK2), .TURN_SECONDS(TS2), .SQUARE_WIDTH(8)) dut_t (
        .clock(clock), .resetApp(resetApp), .KeySelect(KeyIdle), .KeyCancel(KeyIdle),
        .CursorIdx(CursorIdx), .RdIdx(RdIdx2), .RdData(RdData2), .WrEn(WrEn2), .WrIdx(WrIdx2),
        .WrData(WrData2), .Turn(Turn2), .SrcValid(SrcValid2), .SrcIdx(SrcIdx2),
        .WhiteTime(WhiteTime2), .BlackTime(BlackTime2), .GameOver(GameOver2), .Winner(Winner2));

    always #5 clock = ~clock;

    // board memory: registered read, write port driven by the DUT
    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (WrEn) begin
            mem[WrIdx] <= WrData;
        end
        RdData <= mem[RdIdx];
    end

    always @(posedge clock or negedge resetApp) begin
        if (!resetApp) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (resetApp && WrEn) begin
            wq_idx.push_back(int'(WrIdx));
            wq_dat.push_back(WrData);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetApp = 1'b0; KeySelect = 1'b1; KeyCancel = 1'b1;
        repeat (3) @(negedge clock);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        resetApp = 1'b1;
        for (int i = 0; i < 64; i++) mb[i] = init_mem[i];
        m_turn = 0; m_sv = 0; m_over = 0; m_win = 0; m_src = 0;
    endtask

    // press keys at a negedge, hold 3 edges, release, settle 6 more edges
    task automatic act(input bit sel, input bit can, input int c, output int c0);
        CursorIdx = 6'(c);
        KeySelect = !sel;
        KeyCancel = !can;
        c0 = cyc;
        repeat (3) @(posedge clock);
        @(negedge clock);
        KeySelect = 1'b1; KeyCancel = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    // game rules at the level of whole key actions
    task automatic model_act(input bit sel, input bit can, input int c, output bit moved);
        logic [3:0] p;
        bit ownp;
        moved = 0;
        if (m_over) return;
        p = mb[c][3:0];
        ownp = (p != 0) && (p[3] == m_turn);
        if (can) begin
            m_sv = 0;
        end else if (sel) begin
            if (!m_sv) begin
                if (ownp) begin m_sv = 1; m_src = c; end
            end else if (c == m_src) begin
                m_sv = 0;
            end else if (!ownp) begin
                mb[c] = {4'h0, mb[m_src][3:0]};
                mb[m_src] = 8'h00;
                m_sv = 0;
                moved = 1;
                if (p[2:0] == 3'd6) begin m_over = 1; m_win = m_turn; end
                else m_turn = !m_turn;
            end
        end
    endtask

    task automatic clear_init();
        for (int i = 0; i < 64; i++) init_mem[i] = 8'h00;
    endtask

    task automatic test_reset();
        int base;
        clear_init();
        @(negedge clock);
        resetApp = 1'b0; KeySelect = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (WrEn !== 1'b0 || WrIdx !== 6'd0 || WrData !== 8'h00) begin failures++;
            $display("FAIL reset_write: WrEn=%0b WrIdx=%0d WrData=%h expected 0 0 00", WrEn, WrIdx, WrData); end
        checks++; if (Turn !== 1'b0 || SrcValid !== 1'b0 || GameOver !== 1'b0 || Winner !== 1'b0) begin failures++;
            $display("FAIL reset_flags: Turn=%0b SrcValid=%0b GameOver=%0b Winner=%0b expected 0", Turn, SrcValid, GameOver, Winner); end
        checks++; if (WhiteTime !== 10'(TS) || BlackTime !== 10'(TS)) begin failures++;
            $display("FAIL reset_times: white=%0d black=%0d expected %0d", WhiteTime, BlackTime, TS); end
        checks++; if (RdIdx !== 6'd0 || SrcIdx !== 6'd0) begin failures++;
            $display("FAIL reset_idx: RdIdx=%0d SrcIdx=%0d expected 0", RdIdx, SrcIdx); end
        do_reset();
        base = wq_idx.size();
        repeat (10) @(negedge clock);
        checks++; if (wq_idx.size() !== base) begin failures++;
            $display("FAIL idle_writes: got %0d writes expected 0", wq_idx.size() - base); end
    endtask

    task automatic test_legal_move();
        int base, c0, c1;
        clear_init();
        init_mem[52] = 8'h01;
        do_reset();
        base = wq_idx.size();
        CursorIdx = 6'd52; KeySelect = 1'b0; c0 = cyc;
        repeat (3) @(posedge clock);
        @(negedge clock); KeySelect = 1'b1;
        @(negedge clock);
        checks++; if (SrcValid !== 1'b0) begin failures++;
            $display("FAIL src_latency_early: SrcValid=%0b at edge %0d expected 0", SrcValid, cyc - c0); end
        @(negedge clock);
        checks++; if (SrcValid !== 1'b1 || SrcIdx !== 6'd52) begin failures++;
            $display("FAIL src_latency: SrcValid=%0b SrcIdx=%0d expected 1 52", SrcValid, SrcIdx); end
        repeat (4) @(negedge clock);
        act(1, 0, 36, c1);
        checks++; if (wq_idx.size() - base !== 2) begin failures++;
            $display("FAIL move_write_count: got %0d expected 2", wq_idx.size() - base); end
        else begin
            checks++; if (wq_idx[base] !== 36 || wq_dat[base] !== 8'h01 || wq_cyc[base] !== c1 + 5) begin failures++;
                $display("FAIL move_write_dst: idx=%0d data=%h edge=%0d expected 36 01 %0d", wq_idx[base], wq_dat[base], wq_cyc[base] - c1, 5); end
            checks++; if (wq_idx[base+1] !== 52 || wq_dat[base+1] !== 8'h00 || wq_cyc[base+1] !== c1 + 6) begin failures++;
                $display("FAIL move_write_src: idx=%0d data=%h edge=%0d expected 52 00 %0d", wq_idx[base+1], wq_dat[base+1], wq_cyc[base+1] - c1, 6); end
        end
        checks++; if (Turn !== 1'b1 || SrcValid !== 1'b0) begin failures++;
            $display("FAIL move_turn: Turn=%0b SrcValid=%0b expected 1 0", Turn, SrcValid); end
    endtask

    task automatic test_rejects();
        int base, c0;
        clear_init();
        init_mem[10] = 8'h09; init_mem[20] = 8'h01; init_mem[30] = 8'h02;
        do_reset();
        base = wq_idx.size();
        act(1, 0, 10, c0);
        checks++; if (SrcValid !== 1'b0) begin failures++;
            $display("FAIL reject_enemy_src: SrcValid=%0b expected 0", SrcValid); end
        act(1, 0, 20, c0);
        checks++; if (SrcValid !== 1'b1 || SrcIdx !== 6'd20) begin failures++;
            $display("FAIL accept_src: SrcValid=%0b SrcIdx=%0d expected 1 20", SrcValid, SrcIdx); end
        act(1, 0, 30, c0);
        checks++; if (SrcValid !== 1'b1 || SrcIdx !== 6'd20 || wq_idx.size() !== base) begin failures++;
            $display("FAIL reject_own_dst: SrcValid=%0b SrcIdx=%0d writes=%0d expected 1 20 0", SrcValid, SrcIdx, wq_idx.size() - base); end
        act(1, 0, 20, c0);
        checks++; if (SrcValid !== 1'b0) begin failures++;
            $display("FAIL deselect_src: SrcValid=%0b expected 0", SrcValid); end
        act(1, 0, 20, c0);
        act(1, 1, 40, c0);
        checks++; if (SrcValid !== 1'b0 || wq_idx.size() !== base || Turn !== 1'b0) begin failures++;
            $display("FAIL cancel_wins: SrcValid=%0b writes=%0d Turn=%0b expected 0 0 0", SrcValid, wq_idx.size() - base, Turn); end
    endtask

    task automatic test_king_capture();
        int base, c0, c1, cgo;
        clear_init();
        init_mem[10] = 8'h05; init_mem[20] = 8'h0E;
        do_reset();
        base = wq_idx.size();
        act(1, 0, 10, c0);
        act(1, 0, 20, c1);
        cgo = c1 + 7;
        checks++; if (wq_idx.size() - base !== 2 || mem[20] !== 8'h05 || mem[10] !== 8'h00) begin failures++;
            $display("FAIL king_writes: writes=%0d sq20=%h sq10=%h expected 2 05 00", wq_idx.size() - base, mem[20], mem[10]); end
        checks++; if (GameOver !== 1'b1 || Winner !== 1'b0 || Turn !== 1'b0 || SrcValid !== 1'b0) begin failures++;
            $display("FAIL king_over: GameOver=%0b Winner=%0b Turn=%0b SrcValid=%0b expected 1 0 0 0", GameOver, Winner, Turn, SrcValid); end
        repeat (3 * TK) @(negedge clock);
        checks++; if (int'(WhiteTime) !== TS - cgo / TK || int'(BlackTime) !== TS) begin failures++;
            $display("FAIL king_frozen: white=%0d black=%0d expected %0d %0d", WhiteTime, BlackTime, TS - cgo / TK, TS); end
        base = wq_idx.size();
        act(1, 0, 10, c0);
        act(1, 0, 30, c0);
        checks++; if (wq_idx.size() !== base || GameOver !== 1'b1 || SrcValid !== 1'b0) begin failures++;
            $display("FAIL over_keys_ignored: writes=%0d GameOver=%0b SrcValid=%0b expected 0 1 0", wq_idx.size() - base, GameOver, SrcValid); end
    endtask

    task automatic test_timeout();
        clear_init();
        do_reset();
        repeat (11) @(negedge clock);
        checks++; if (WhiteTime2 !== 10'd1 || GameOver2 !== 1'b0) begin failures++;
            $display("FAIL timeout_pre: white=%0d GameOver=%0b expected 1 0", WhiteTime2, GameOver2); end
        @(negedge clock);
        checks++; if (WhiteTime2 !== 10'd0 || GameOver2 !== 1'b0) begin failures++;
            $display("FAIL timeout_zero: white=%0d GameOver=%0b expected 0 0", WhiteTime2, GameOver2); end
        @(negedge clock);
        checks++; if (GameOver2 !== 1'b1 || Winner2 !== 1'b1 || BlackTime2 !== 10'(TS2) || SrcValid2 !== 1'b0) begin failures++;
            $display("FAIL timeout_over: GameOver=%0b Winner=%0b black=%0d expected 1 1 %0d", GameOver2, Winner2, BlackTime2, TS2); end
        repeat (12) @(negedge clock);
        checks++; if (GameOver2 !== 1'b1 || BlackTime2 !== 10'(TS2) || WhiteTime2 !== 10'd0 || WrEn2 !== 1'b0) begin failures++;
            $display("FAIL timeout_frozen: GameOver=%0b black=%0d white=%0d WrEn=%0b expected 1 %0d 0 0", GameOver2, BlackTime2, WhiteTime2, WrEn2, TS2); end
    endtask

    task automatic test_reset_mid_write();
        int c0, c1;
        clear_init();
        init_mem[52] = 8'h01; init_mem[36] = 8'hA0;
        do_reset();
        act(1, 0, 52, c0);
        CursorIdx = 6'd36; KeySelect = 1'b0; c1 = cyc;
        repeat (3) @(posedge clock);
        @(negedge clock); KeySelect = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (WrEn !== 1'b1 || WrIdx !== 6'd36 || WrData !== 8'h01) begin failures++;
            $display("FAIL mid_write_enter: WrEn=%0b WrIdx=%0d WrData=%h expected 1 36 01", WrEn, WrIdx, WrData); end
        #1 resetApp = 1'b0;
        #1;
        checks++; if (WrEn !== 1'b0 || WrIdx !== 6'd0 || WrData !== 8'h00 || SrcValid !== 1'b0 || RdIdx !== 6'd0) begin failures++;
            $display("FAIL mid_write_async: WrEn=%0b WrIdx=%0d WrData=%h SrcValid=%0b RdIdx=%0d expected 0 0 00 0 0", WrEn, WrIdx, WrData, SrcValid, RdIdx); end
        checks++; if (Turn !== 1'b0 || GameOver !== 1'b0 || WhiteTime !== 10'(TS) || BlackTime !== 10'(TS)) begin failures++;
            $display("FAIL mid_write_state: Turn=%0b GameOver=%0b white=%0d black=%0d expected 0 0 %0d", Turn, GameOver, WhiteTime, BlackTime, TS); end
        repeat (3) @(negedge clock);
        checks++; if (mem[36] !== 8'hA0 || mem[52] !== 8'h01) begin failures++;
            $display("FAIL mid_write_board: sq36=%h sq52=%h expected a0 01", mem[36], mem[52]); end
        resetApp = 1'b1;
    endtask

    task automatic test_random();
        int base, c0, c, r, bad, nmoves;
        bit sel, can, moved;
        for (int i = 0; i < 64; i++) begin
            logic [3:0] ov;
            ov = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) init_mem[i] = {ov, 4'h0};
            else init_mem[i] = {ov, 1'($urandom_range(0, 1)), 3'($urandom_range(1, 5))};
        end
        do_reset();
        nmoves = 0;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            sel = (r != 0);
            can = (r <= 1);
            if (m_sv && $urandom_range(0, 3) == 0) c = m_src;
            else c = $urandom_range(0, 63);
            base = wq_idx.size();
            model_act(sel, can, c, moved);
            act(sel, can, c, c0);
            if (moved) nmoves++;
            checks++; if (Turn !== m_turn || SrcValid !== m_sv || GameOver !== m_over) begin failures++;
                $display("FAIL rand_state[%0d]: Turn=%0b SrcValid=%0b GameOver=%0b expected %0b %0b %0b", n, Turn, SrcValid, GameOver, m_turn, m_sv, m_over); end
            if (m_sv) begin
                checks++; if (int'(SrcIdx) !== m_src) begin failures++;
                    $display("FAIL rand_src[%0d]: SrcIdx=%0d expected %0d", n, SrcIdx, m_src); end
            end
            checks++; if (wq_idx.size() - base !== (moved ? 2 : 0)) begin failures++;
                $display("FAIL rand_write_count[%0d]: got %0d expected %0d", n, wq_idx.size() - base, moved ? 2 : 0); end
            else if (moved) begin
                checks++; if (wq_cyc[base] !== c0 + 5 || wq_cyc[base+1] !== c0 + 6 || wq_idx[base] !== c) begin failures++;
                    $display("FAIL rand_write_order[%0d]: idx=%0d edges=%0d,%0d expected %0d 5,6", n, wq_idx[base], wq_cyc[base] - c0, wq_cyc[base+1] - c0, c); end
            end
            bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== mb[i]) bad++;
            checks++; if (bad !== 0) begin failures++;
                $display("FAIL rand_board[%0d]: %0d squares differ expected 0", n, bad); end
            checks++; if (int'(WhiteTime) + int'(BlackTime) !== 2 * TS - cyc / TK) begin failures++;
                $display("FAIL rand_clock[%0d]: white+black=%0d expected %0d", n, int'(WhiteTime) + int'(BlackTime), 2 * TS - cyc / TK); end
        end
        checks++; if (nmoves == 0 && wq_idx.size() !== 0) begin failures++;
            $display("FAIL rand_activity: no model moves but %0d writes seen", wq_idx.size()); end
    endtask

    initial begin
        test_reset();
        test_legal_move();
        test_rejects();
        test_king_capture();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
